// File: rtl/if_id_reg_if.sv
// IF/ID pipeline register bundle.
// Fetch-side inputs, hazard controls and decode-side outputs.
interface if_id_reg_if #(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 16
);
  logic               stall;
  logic               flush;
  logic [INSTR_W-1:0] instr_in;
  logic [PC_W-1:0]    pc_plus2_in;
  logic               valid_in;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0]    pc_plus2_out;
  logic               valid_out;
  logic               halt_seen;

  modport master (
    output stall,
    output flush,
    output instr_in,
    output pc_plus2_in,
    output valid_in,
    input  instr_out,
    input  pc_plus2_out,
    input  valid_out,
    input  halt_seen
  );

  modport slave (
    input  stall,
    input  flush,
    input  instr_in,
    input  pc_plus2_in,
    input  valid_in,
    output instr_out,
    output pc_plus2_out,
    output valid_out,
    output halt_seen
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall, flush and HALT tracking.
// Storage is one enabled D flip-flop cell per bit.
module if_id_dffe #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);
  logic r_q;

  // Sync reset to the cell's own value, else load when enabled.
  always_ff @(posedge clk) begin
    if (i_rst)
      r_q <= RST_VAL;
    else if (i_en)
      r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module if_id_reg #(
  parameter int                 INSTR_W   = 16,
  parameter int                 PC_W      = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]         HALT_OP   = 5'b00000
) (
  input logic          clk,
  input logic          rst,
  if_id_reg_if.slave   bus
);
  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } halt_st_t;

  halt_st_t r_state;
  logic     r_halt;

  logic               w_load;
  logic               w_bubble;
  logic               w_en;
  logic               w_is_halt;
  logic [INSTR_W-1:0] w_d_instr;
  logic [PC_W-1:0]    w_d_pc;
  logic               w_d_valid;
  logic [INSTR_W-1:0] w_q_instr;
  logic [PC_W-1:0]    w_q_pc;
  logic               w_q_valid;

  // A load happens only when not flushing, halted or stalled.
  assign w_load = !bus.flush && !r_halt && !bus.stall;

  // Flushes and invalid fetch slots both become a NOP bubble.
  assign w_bubble = bus.flush || !bus.valid_in;

  assign w_en = bus.flush || w_load;

  assign w_is_halt = bus.valid_in &&
    (bus.instr_in[INSTR_W-1 -: 5] == HALT_OP);

  // Next-value mux shared by all data cells.
  always_comb begin
    w_d_instr = bus.instr_in;
    w_d_pc    = bus.pc_plus2_in;
    w_d_valid = bus.valid_in && !bus.flush;
    if (w_bubble) begin
      w_d_instr = NOP_INSTR;
      w_d_pc    = '0;
    end
  end

  for (genvar gi = 0; gi < INSTR_W; gi++) begin : g_instr
    if_id_dffe #(
      .RST_VAL (NOP_INSTR[gi])
    ) u_cell (
      .clk   (clk),
      .i_rst (rst),
      .i_en  (w_en),
      .i_d   (w_d_instr[gi]),
      .o_q   (w_q_instr[gi])
    );
  end

  for (genvar gp = 0; gp < PC_W; gp++) begin : g_pc
    if_id_dffe #(
      .RST_VAL (1'b0)
    ) u_cell (
      .clk   (clk),
      .i_rst (rst),
      .i_en  (w_en),
      .i_d   (w_d_pc[gp]),
      .o_q   (w_q_pc[gp])
    );
  end

  if_id_dffe #(
    .RST_VAL (1'b0)
  ) u_valid (
    .clk   (clk),
    .i_rst (rst),
    .i_en  (w_en),
    .i_d   (w_d_valid),
    .o_q   (w_q_valid)
  );

  // HALT tracker: set with the HALT word, cleared by rst or flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_halt  <= 1'b0;
    end else begin
      unique case (1'b1)
        bus.flush: begin
          r_state <= RUN;
          r_halt  <= 1'b0;
        end
        (r_state == RUN) && w_load && w_is_halt: begin
          r_state <= HALTED;
          r_halt  <= 1'b1;
        end
        default: begin
          r_state <= r_state;
          r_halt  <= r_halt;
        end
      endcase
    end
  end

  assign bus.instr_out    = w_q_instr;
  assign bus.pc_plus2_out = w_q_pc;
  assign bus.valid_out    = w_q_valid;
  assign bus.halt_seen    = r_halt;
endmodule

// File: tb/tb_if_id_reg.sv
// Directed bench for the IF/ID pipeline register.
// Expected values are hand-computed per step.
module tb_if_id_reg;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  if_id_reg_if #(.INSTR_W(16), .PC_W(16)) bus ();

  if_id_reg #(
    .INSTR_W   (16),
    .PC_W      (16),
    .NOP_INSTR (16'h0800),
    .HALT_OP   (5'b00000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [15:0] i,
                         input logic [15:0] p,
                         input logic v,
                         input logic h);
    chk({tag, ".instr"}, 32'(bus.instr_out), 32'(i));
    chk({tag, ".pc"}, 32'(bus.pc_plus2_out), 32'(p));
    chk({tag, ".valid"}, 32'(bus.valid_out), 32'(v));
    chk({tag, ".halt"}, 32'(bus.halt_seen), 32'(h));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] i,
                       input logic [15:0] p,
                       input logic v);
    bus.instr_in    = i;
    bus.pc_plus2_in = p;
    bus.valid_in    = v;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(16'hC123, 16'h0042, 1'b1);

    step(); chk_all("rst0", 16'h0800, 16'h0000, 1'b0, 1'b0);
    step(); chk_all("rst1", 16'h0800, 16'h0000, 1'b0, 1'b0);

    rst = 1'b0;
    drive(16'h4A21, 16'h0006, 1'b1);
    step(); chk_all("load", 16'h4A21, 16'h0006, 1'b1, 1'b0);

    drive(16'h9999, 16'h0008, 1'b1);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); chk_all($sformatf("stall%0d", k),
                      16'h4A21, 16'h0006, 1'b1, 1'b0);
    end
    bus.stall = 1'b0;
    step(); chk_all("unstall", 16'h9999, 16'h0008, 1'b1, 1'b0);

    drive(16'h4A21, 16'hFFFE, 1'b1);
    step(); chk_all("pcwrap", 16'h4A21, 16'hFFFE, 1'b1, 1'b0);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    step(); chk_all("flushstall", 16'h0800, 16'h0000, 1'b0, 1'b0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    drive(16'h0000, 16'h000A, 1'b1);
    step(); chk_all("haltcap", 16'h0000, 16'h000A, 1'b1, 1'b1);
    drive(16'h1234, 16'h000C, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(); chk_all($sformatf("halthold%0d", k),
                      16'h0000, 16'h000A, 1'b1, 1'b1);
    end
    bus.flush = 1'b1;
    step(); chk_all("haltflush", 16'h0800, 16'h0000, 1'b0, 1'b0);
    bus.flush = 1'b0;
    step(); chk_all("resume", 16'h1234, 16'h000C, 1'b1, 1'b0);

    drive(16'h0000, 16'h00EE, 1'b0);
    step(); chk_all("invalid", 16'h0800, 16'h0000, 1'b0, 1'b0);

    drive(16'h0800, 16'h0010, 1'b1);
    step(); chk_all("op1", 16'h0800, 16'h0010, 1'b1, 1'b0);

    drive(16'h07FF, 16'h0012, 1'b1);
    bus.stall = 1'b1;
    step(); chk_all("haltstall", 16'h0800, 16'h0010, 1'b1, 1'b0);
    bus.stall = 1'b0;
    step(); chk_all("haltlate", 16'h07FF, 16'h0012, 1'b1, 1'b1);

    rst = 1'b1;
    step(); chk_all("rsthalt", 16'h0800, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    drive(16'h2222, 16'h0004, 1'b1);
    step(); chk_all("postrst", 16'h2222, 16'h0004, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
- Pipeline register between instruction fetch and decode in the 5-stage 16-bit CPU.
- Captures the fetched instruction, PC+2 and a valid bit each cycle. Supports hazard-unit stall (hold) and branch/jump flush (bubble insertion).
- Tracks a fetched HALT so that decode sees a stable HALT and fetch stops advancing.
- Storage is built from the team's enabled D-flip-flop cells, one per bit.

Parameters:
- INSTR_W, 16, instruction width in bits.
- PC_W, 16, PC width in bits.
- NOP_INSTR, 16'h0800, encoding driven into decode for a bubble (opcode 00001).
- HALT_OP, 5'b00000, opcode in bits [15:11] that identifies HALT.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- stall  input  1  from hazard unit: hold all contents this cycle.
- flush  input  1  from branch resolution: replace contents with a bubble.
- instr_in  input  INSTR_W  instruction from the fetch stage.
- pc_plus2_in  input  PC_W  PC+2 from the fetch stage.
- valid_in  input  1  fetch output is a real instruction.
- instr_out  output  INSTR_W  instruction to decode.
- pc_plus2_out  output  PC_W  PC+2 to decode.
- valid_out  output  1  decode slot holds a real instruction.
- halt_seen  output  1  a valid HALT is held; fetch must freeze its PC.

Behaviour:
- Clock, reset and outputs:
  - Single clock. Reset is synchronous and active-high, sampled on the rising clk edge.
  - All outputs are driven directly from registers. There is no combinational path from any input to any output.
  - Latency from input to output is 1 cycle.
- Reset values: instr_out=NOP_INSTR, pc_plus2_out=0, valid_out=0, halt_seen=0.
- Update priority at each rising edge (highest first):
  1. rst: apply the reset values.
  2. flush: instr_out=NOP_INSTR, pc_plus2_out=0, valid_out=0, halt_seen=0. Flush overrides stall and halt. A HALT fetched down a wrong path is discarded.
  3. halt_seen=1: hold all contents. Only rst or flush leave this state.
  4. stall: hold all contents, including halt_seen.
  5. Otherwise, load:
     - instr_out=instr_in, pc_plus2_out=pc_plus2_in, valid_out=valid_in.
     - If valid_in=0, instr_out=NOP_INSTR and pc_plus2_out=0 instead.
- State machine, on halt_seen:
  - RUN (halt_seen=0) to HALTED: on a load where valid_in=1 and instr_in[15:11]=HALT_OP. halt_seen becomes 1 in the same edge as the HALT word.
  - HALTED to RUN: on flush.
  - HALTED or RUN to RUN with reset values: on rst.
  - A HALT presented while stall=1 is not captured. It is captured on the first edge with stall=0.
- Simultaneous events:
  - stall and flush together: the flush wins.
  - rst during HALTED or stall: reset wins, and the next load resumes normally.
  - Repeated stall cycles: contents are held indefinitely with no decay.
- Widths: pc_plus2_in/out are PC_W bits, passed through unmodified with no arithmetic. Wrap-around is owned by fetch.

Test Plan:
- Reset: rst=1 for 2 cycles with instr_in=16'hC123 and valid_in=1 -> after each edge instr_out=16'h0800, pc_plus2_out=0, valid_out=0, halt_seen=0.
- Load: rst=0, instr_in=16'h4A21, pc_plus2_in=16'h0006, valid_in=1 -> one edge later instr_out=16'h4A21, pc_plus2_out=16'h0006, valid_out=1. Change instr_in to 16'h9999 and assert stall for 3 cycles -> outputs stay 16'h4A21/16'h0006/1; on the edge after stall drops, instr_out=16'h9999.
- Flush beats stall: holding 16'h4A21, assert stall=1 and flush=1 together -> next edge instr_out=16'h0800, pc_plus2_out=0, valid_out=0.
- Halt capture: instr_in=16'h0000, valid_in=1 -> halt_seen=1 and instr_out=16'h0000 after one edge. Then feed 16'h1234 for 4 cycles -> outputs unchanged and halt_seen stays 1.
- Halt cleared: from the halt-capture state, assert flush -> halt_seen=0, instr_out=16'h0800. The next load of 16'h1234 appears on the following edge.
- Invalid input: instr_in=16'h0000, valid_in=0 -> instr_out=16'h0800, valid_out=0, halt_seen stays 0.
